pattern_scheduler: RTL and testbench

//   Frame-synchronous sequencer for the VGA pattern generators. Picks the active pattern,

---
 rtl/pattern_scheduler.sv | 165 ++++++++++++++++
 tb/tb_pattern_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scheduler.sv
// pattern_scheduler: frame-synchronous pattern sequencer with blanking between switches.
// Define PATTERN_SCHED_PREV_EN to add the btn_prev reverse-step button.
module pattern_scheduler #(
    parameter int unsigned NUM_PATTERNS       = 3,
    parameter int unsigned FRAMES_PER_PATTERN = 300,
    parameter int unsigned BLANK_FRAMES       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       paused,
    input  logic       auto_en,
    input  logic       btn_next,
`ifdef PATTERN_SCHED_PREV_EN
    input  logic       btn_prev,
`endif
    output logic [1:0] pattern_select,
    output logic [3:0] next_frame,
    output logic [3:0] pattern_rst,
    output logic       blank,
    output logic [8:0] frame_count
);
    localparam logic [1:0] SEL_LAST  = 2'(NUM_PATTERNS - 1);
    localparam logic [8:0] FC_LAST   = 9'(FRAMES_PER_PATTERN - 1);
    localparam logic [2:0] BL_LAST   = 3'(BLANK_FRAMES - 1);
    localparam bit         HAS_BLANK = (BLANK_FRAMES != 0);

    typedef enum logic {
        ST_SHOW,
        ST_BLANK
    } state_e;

    state_e     state_q;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic [8:0] fc_q;
    logic [2:0] blank_cnt_q;
    logic       blank_q;
    logic [3:0] next_frame_q;
    logic [3:0] pattern_rst_q;
    logic       vsync_q;
    logic [2:0] nsync_q;
    logic       next_pend_q;

    logic tick;
    logic run;
    logic timeout;
    logic next_edge;
    logic next_req;
    logic go_fwd;
    logic go_back;

`ifdef PATTERN_SCHED_PREV_EN
    logic [2:0] psync_q;
    logic       prev_pend_q;
    logic       prev_edge;
    logic       prev_req;
`endif

    always_comb begin
        tick      = vsync & ~vsync_q;
        run       = auto_en & ~paused;
        timeout   = run & (fc_q == FC_LAST);
        // [1] is the synchronised level, [2] its previous value
        next_edge = nsync_q[1] & ~nsync_q[2];
        next_req  = next_pend_q | next_edge;
`ifdef PATTERN_SCHED_PREV_EN
        prev_edge = psync_q[1] & ~psync_q[2];
        prev_req  = prev_pend_q | prev_edge;
        go_back   = prev_req & ~next_req;
        go_fwd    = ~go_back & (timeout | (next_req & ~prev_req));
`else
        go_back   = 1'b0;
        go_fwd    = timeout | next_req;
`endif
        sel_d = sel_q;
        if (go_back) begin
            sel_d = (sel_q == 2'd0) ? SEL_LAST : sel_q - 2'd1;
        end else if (go_fwd) begin
            sel_d = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SHOW;
            sel_q         <= 2'd0;
            fc_q          <= 9'd0;
            blank_cnt_q   <= 3'd0;
            blank_q       <= 1'b0;
            next_frame_q  <= 4'd0;
            pattern_rst_q <= 4'd0;
            vsync_q       <= 1'b1;
            nsync_q       <= 3'd0;
            next_pend_q   <= 1'b0;
`ifdef PATTERN_SCHED_PREV_EN
            psync_q       <= 3'd0;
            prev_pend_q   <= 1'b0;
`endif
        end else begin
            vsync_q       <= vsync;
            nsync_q       <= {nsync_q[1:0], btn_next};
`ifdef PATTERN_SCHED_PREV_EN
            psync_q       <= {psync_q[1:0], btn_prev};
`endif
            next_frame_q  <= 4'd0;
            pattern_rst_q <= 4'd0;
            unique case (state_q)
                ST_SHOW: begin
                    if (tick) begin
                        next_pend_q <= 1'b0;
`ifdef PATTERN_SCHED_PREV_EN
                        prev_pend_q <= 1'b0;
`endif
                        if (go_fwd | go_back) begin
                            sel_q         <= sel_d;
                            fc_q          <= 9'd0;
                            pattern_rst_q <= 4'b0001 << sel_d;
                            if (HAS_BLANK) begin
                                state_q     <= ST_BLANK;
                                blank_q     <= 1'b1;
                                blank_cnt_q <= 3'd0;
                            end
                        end else begin
                            if (run) begin
                                fc_q <= fc_q + 9'd1;
                            end
                            if (!paused) begin
                                next_frame_q <= 4'b0001 << sel_q;
                            end
                        end
                    end else begin
                        if (next_edge) begin
                            next_pend_q <= 1'b1;
                        end
`ifdef PATTERN_SCHED_PREV_EN
                        if (prev_edge) begin
                            prev_pend_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_BLANK: begin
                    // button edges seen here are intentionally dropped
                    if (tick) begin
                        if (blank_cnt_q == BL_LAST) begin
                            state_q <= ST_SHOW;
                            blank_q <= 1'b0;
                        end else begin
                            blank_cnt_q <= blank_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= ST_SHOW;
            endcase
        end
    end

    assign pattern_select = sel_q;
    assign next_frame     = next_frame_q;
    assign pattern_rst    = pattern_rst_q;
    assign blank          = blank_q;
    assign frame_count    = fc_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler: vector table, directed frame sequences and
// randomized frames checked against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_pattern_scheduler;
    localparam int NP  = 3;
    localparam int FPP = 300;
    localparam int BF  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       paused = 1'b0;
    logic       auto_en = 1'b0;
    logic       btn_next = 1'b0;
`ifdef PATTERN_SCHED_PREV_EN
    logic       btn_prev = 1'b0;
`endif
    logic [1:0] pattern_select;
    logic [3:0] next_frame;
    logic [3:0] pattern_rst;
    logic       blank;
    logic [8:0] frame_count;

    int errors = 0;
    int checks = 0;
    int nf_cnt = 0;
    int rst_cnt = 0;
    logic [3:0] nf_snap;
    logic [3:0] rst_snap;

    // frame-level model state
    int m_sel = 0;
    int m_fc = 0;
    int m_blank = 0;
    bit m_pn = 0;
    bit m_pp = 0;
    logic [3:0] m_nf;
    logic [3:0] m_rst;

    typedef struct {
        bit p;
        bit a;
        bit en;
        bit ln;
        int sel;
        bit bl;
        int fc;
        logic [3:0] nf;
        logic [3:0] rst;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    pattern_scheduler #(
        .NUM_PATTERNS(NP),
        .FRAMES_PER_PATTERN(FPP),
        .BLANK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vsync(vsync),
        .paused(paused),
        .auto_en(auto_en),
        .btn_next(btn_next),
`ifdef PATTERN_SCHED_PREV_EN
        .btn_prev(btn_prev),
`endif
        .pattern_select(pattern_select),
        .next_frame(next_frame),
        .pattern_rst(pattern_rst),
        .blank(blank),
        .frame_count(frame_count)
    );

    always @(negedge clk) begin
        if (next_frame != 4'd0) nf_cnt++;
        if (pattern_rst != 4'd0) rst_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_sel = 0; m_fc = 0; m_blank = 0; m_pn = 0; m_pp = 0;
    endfunction

    // what one vsync tick does, given the requests that arrived before it
    function automatic void model_tick(bit p, bit a, bit en, bit ep);
        bit nreq, preq, to, back, fwd;
        m_nf = 4'd0;
        m_rst = 4'd0;
        if (m_blank > 0) begin
            m_blank--;
        end else begin
            nreq = m_pn | en;
            preq = m_pp | ep;
            m_pn = 0;
            m_pp = 0;
            to = a && !p && (m_fc == FPP - 1);
            back = preq && !nreq;
            fwd = !back && (to || (nreq && !preq));
            if (back || fwd) begin
                m_sel = back ? (m_sel + NP - 1) % NP : (m_sel + 1) % NP;
                m_fc = 0;
                m_rst = 4'(1 << m_sel);
                m_blank = BF;
            end else begin
                if (a && !p) m_fc++;
                if (!p) m_nf = 4'(1 << m_sel);
            end
        end
    endfunction

    function automatic void model_late(bit ln, bit lp);
        if (m_blank == 0) begin
            if (ln) m_pn = 1;
            if (lp) m_pp = 1;
        end
    endfunction

    // one video frame: optional early press, tick, optional late press
    task automatic run_frame(input bit p, input bit a, input bit en, input bit ln,
                             input bit ep = 0, input bit lp = 0);
        paused = p;
        auto_en = a;
        nf_cnt = 0;
        rst_cnt = 0;
        vsync = 1'b0;
        btn_next = en;
`ifdef PATTERN_SCHED_PREV_EN
        btn_prev = ep;
`endif
        cyc(6);
        btn_next = 1'b0;
`ifdef PATTERN_SCHED_PREV_EN
        btn_prev = 1'b0;
`endif
        vsync = 1'b1;
        model_tick(p, a, en, ep);
        cyc(1);
        nf_snap = next_frame;
        rst_snap = pattern_rst;
        check("next_frame_latency", 32'(nf_snap), 32'(m_nf));
        check("pattern_rst_latency", 32'(rst_snap), 32'(m_rst));
        cyc(1);
        btn_next = ln;
`ifdef PATTERN_SCHED_PREV_EN
        btn_prev = lp;
`endif
        cyc(5);
        btn_next = 1'b0;
`ifdef PATTERN_SCHED_PREV_EN
        btn_prev = 1'b0;
`endif
        cyc(3);
        model_late(ln, lp);
        check("sel", 32'(pattern_select), 32'(m_sel));
        check("blank", 32'(blank), 32'(m_blank > 0));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        check("next_frame_pulses", 32'(nf_cnt), 32'(m_nf != 4'd0));
        check("pattern_rst_pulses", 32'(rst_cnt), 32'(m_rst != 4'd0));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_sel", 32'(pattern_select), 0);
        check("rst_next_frame", 32'(next_frame), 0);
        check("rst_pattern_rst", 32'(pattern_rst), 0);
        check("rst_blank", 32'(blank), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        model_reset();
        vsync = 1'b1;
        btn_next = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int sel0;
        int nf_sum;
        bit rp, ra, ren, rln, rep, rlp;

        //           p  a  en ln sel bl fc  nf       rst
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 1, 4'b0001, 4'b0000};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 2, 4'b0001, 4'b0000};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 2, 4'b0000, 4'b0000};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 2, 4'b0001, 4'b0000};
        tbl[4]  = '{0, 1, 1, 0, 1, 1, 0, 4'b0000, 4'b0010};
        tbl[5]  = '{0, 1, 0, 0, 1, 1, 0, 4'b0000, 4'b0000};
        tbl[6]  = '{0, 1, 1, 0, 1, 0, 0, 4'b0000, 4'b0000};
        tbl[7]  = '{0, 1, 0, 0, 1, 0, 1, 4'b0010, 4'b0000};
        tbl[8]  = '{0, 0, 0, 1, 1, 0, 1, 4'b0010, 4'b0000};
        tbl[9]  = '{1, 0, 0, 0, 2, 1, 0, 4'b0000, 4'b0100};
        tbl[10] = '{0, 1, 0, 0, 2, 1, 0, 4'b0000, 4'b0000};
        tbl[11] = '{0, 1, 0, 1, 2, 0, 0, 4'b0000, 4'b0000};
        tbl[12] = '{0, 1, 0, 0, 0, 1, 0, 4'b0000, 4'b0001};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 0, 4'b0000, 4'b0000};
        tbl[14] = '{0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 1, 4'b0001, 4'b0000};

        cyc(3);
        check("init_sel", 32'(pattern_select), 0);
        check("init_next_frame", 32'(next_frame), 0);
        check("init_pattern_rst", 32'(pattern_rst), 0);
        check("init_blank", 32'(blank), 0);
        check("init_frame_count", 32'(frame_count), 0);
        rst_n = 1'b1;
        cyc(2);

        for (int i = 0; i < 16; i++) begin
            run_frame(tbl[i].p, tbl[i].a, tbl[i].en, tbl[i].ln);
            check($sformatf("tbl%0d_sel", i), 32'(pattern_select), 32'(tbl[i].sel));
            check($sformatf("tbl%0d_blank", i), 32'(blank), 32'(tbl[i].bl));
            check($sformatf("tbl%0d_fc", i), 32'(frame_count), 32'(tbl[i].fc));
            check($sformatf("tbl%0d_nf", i), 32'(nf_snap), 32'(tbl[i].nf));
            check($sformatf("tbl%0d_rst", i), 32'(rst_snap), 32'(tbl[i].rst));
        end

        // timed rotation 0 -> 1 after 300 frames
        do_reset();
        repeat (FPP - 1) run_frame(0, 1, 0, 0);
        check("t1_fc_299", 32'(frame_count), 299);
        check("t1_sel_still_0", 32'(pattern_select), 0);
        run_frame(0, 1, 0, 0);
        check("t1_sel_1", 32'(pattern_select), 1);
        check("t1_rst_0010", 32'(rst_snap), 32'h2);
        check("t1_blank", 32'(blank), 1);
        check("t1_fc_0", 32'(frame_count), 0);
        run_frame(0, 1, 0, 0);
        check("t1_blank_f1", 32'(blank), 1);
        run_frame(0, 1, 0, 0);
        check("t1_blank_end", 32'(blank), 0);

        // skip to 2, then timeout wraps to 0
        run_frame(0, 1, 1, 0);
        run_frame(0, 1, 0, 0);
        run_frame(0, 1, 0, 0);
        check("t2_sel_2", 32'(pattern_select), 2);
        repeat (FPP - 1) run_frame(0, 1, 0, 0);
        run_frame(0, 1, 0, 0);
        check("t2_wrap_sel_0", 32'(pattern_select), 0);
        check("t2_rst_0001", 32'(rst_snap), 32'h1);
        run_frame(0, 1, 0, 0);
        check("t2_no_nf_1", 32'(nf_snap), 0);
        run_frame(0, 1, 0, 0);
        check("t2_no_nf_2", 32'(nf_snap), 0);
        run_frame(0, 1, 0, 0);
        check("t2_nf0_third", 32'(nf_snap), 32'h1);

        // manual mode: holds, late press switches on the next tick only
        sel0 = m_sel;
        repeat (300) run_frame(0, 0, 0, 0);
        check("t3_sel_hold", 32'(pattern_select), 32'(sel0));
        check("t3_fc_hold", 32'(frame_count), 1);
        run_frame(0, 0, 0, 1);
        check("t3_no_switch_yet", 32'(pattern_select), 32'(sel0));
        run_frame(0, 0, 0, 0);
        check("t3_switch", 32'(pattern_select), 32'((sel0 + 1) % NP));
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 0, 0);

        // pause at frame_count 100
        guard = 0;
        while (m_fc != 100 && guard < 400) begin
            run_frame(0, 1, 0, 0);
            guard++;
        end
        check("t4_reach_100", 32'(frame_count), 100);
        nf_sum = 0;
        repeat (50) begin
            run_frame(1, 1, 0, 0);
            nf_sum += nf_cnt;
        end
        check("t4_paused_nf", 32'(nf_sum), 0);
        check("t4_paused_fc", 32'(frame_count), 100);
        run_frame(0, 1, 0, 0);
        check("t4_resume_fc", 32'(frame_count), 101);

        // skip on the timeout frame: one advance; press in blank ignored
        guard = 0;
        while (m_fc != FPP - 1 && guard < 400) begin
            run_frame(0, 1, 0, 0);
            guard++;
        end
        sel0 = m_sel;
        run_frame(0, 1, 1, 0);
        check("t5_single_adv", 32'(pattern_select), 32'((sel0 + 1) % NP));
        run_frame(0, 1, 1, 0);
        run_frame(0, 1, 0, 0);
        run_frame(0, 1, 0, 0);
        check("t5_blank_press_ignored", 32'(pattern_select), 32'((sel0 + 1) % NP));
        check("t5_counting", 32'(frame_count), 1);

        // reset while blanking with sel=1
        do_reset();
        run_frame(0, 1, 1, 0);
        check("t6_sel1_blank", 32'({pattern_select, blank}), 32'({2'd1, 1'b1}));
        do_reset();

`ifdef PATTERN_SCHED_PREV_EN
        run_frame(0, 0, 0, 0, 1, 0);
        check("prev_wrap", 32'(pattern_select), 32'(NP - 1));
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 0, 0);
        sel0 = m_sel;
        run_frame(0, 0, 1, 0, 1, 0);
        check("prev_next_cancel", 32'(pattern_select), 32'(sel0));
`endif

        // randomized frames against the model
        repeat (700) begin
            rp  = ($urandom % 8) == 0;
            ra  = ($urandom % 4) != 0;
            ren = ($urandom % 10) == 0;
            rln = ($urandom % 10) == 0;
`ifdef PATTERN_SCHED_PREV_EN
            rep = ($urandom % 12) == 0;
            rlp = ($urandom % 12) == 0;
`else
            rep = 0;
            rlp = 0;
`endif
            run_frame(rp, ra, ren, rln, rep, rlp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
